// File: rtl/seg_scan_decoder.sv
// rtl/seg_scan_decoder.sv - multiplexed 7-segment scan decoder with frame stability commit
// Optional SEG_ERR_CNT_EN adds a saturating 8-bit err_cnt output.
module seg_scan_decoder #(
  parameter int SETTLE       = 2,
  parameter int STABLE_SCANS = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  seg,
  input  logic [3:0]  dig,
  output logic [15:0] value,
  output logic        valid,
  output logic        err,
`ifdef SEG_ERR_CNT_EN
  output logic [1:0]  err_digit,
  output logic [7:0]  err_cnt
`else
  output logic [1:0]  err_digit
`endif
);

  localparam logic [3:0] SETTLE_L = 4'(SETTLE);
  localparam logic [3:0] SETTLE_M1 = 4'(SETTLE - 1);
  localparam logic [2:0] STABLE_L = 3'(STABLE_SCANS);
  localparam logic [2:0] STABLE_M1 = 3'(STABLE_SCANS - 1);

  logic [3:0]  dig_q, dig_d;
  logic [3:0]  dwell_q, dwell_d;
  logic [15:0] slot_q, slot_d;
  logic [3:0]  seen_q, seen_d;
  logic [15:0] prev_q, prev_d;
  logic [2:0]  stable_q, stable_d;
  logic [15:0] value_q, value_d;
  logic        valid_q, valid_d;
  logic        err_q, err_d;
  logic [1:0]  err_digit_q, err_digit_d;
`ifdef SEG_ERR_CNT_EN
  logic [7:0]  err_cnt_q, err_cnt_d;
`endif

  logic       dig_onehot;
  logic       fire;
  logic       frame_done;
  logic [1:0] dig_idx;
  logic       dec_ok;
  logic [3:0] dec_nib;

  always_comb begin
    dec_ok  = 1'b1;
    dec_nib = 4'h0;
    case (seg)
      7'b0111111: dec_nib = 4'h0;
      7'b0000110: dec_nib = 4'h1;
      7'b1011011: dec_nib = 4'h2;
      7'b1001111: dec_nib = 4'h3;
      7'b1100110: dec_nib = 4'h4;
      7'b1101101: dec_nib = 4'h5;
      7'b1111101: dec_nib = 4'h6;
      7'b0000111: dec_nib = 4'h7;
      7'b1111111: dec_nib = 4'h8;
      7'b1101111: dec_nib = 4'h9;
      7'b1110111: dec_nib = 4'hA;
      7'b1111100: dec_nib = 4'hB;
      7'b0111001: dec_nib = 4'hC;
      7'b1011110: dec_nib = 4'hD;
      7'b1111001: dec_nib = 4'hE;
      7'b1110001: dec_nib = 4'hF;
      default:    dec_ok  = 1'b0;
    endcase
  end

  always_comb begin
    dig_idx = 2'd0;
    case (dig)
      4'b0010: dig_idx = 2'd1;
      4'b0100: dig_idx = 2'd2;
      4'b1000: dig_idx = 2'd3;
      default: dig_idx = 2'd0;
    endcase
  end

  assign dig_onehot = (dig != 4'd0) && ((dig & (dig - 4'd1)) == 4'd0);
  // Sample on the single cycle the dwell steps onto SETTLE; saturation blocks repeats.
  assign fire       = (dig == dig_q) && dig_onehot && (dwell_q == SETTLE_M1);
  assign frame_done = (seen_q == 4'hF);

  always_comb begin
    dig_d       = dig;
    dwell_d     = dwell_q;
    slot_d      = slot_q;
    seen_d      = seen_q;
    prev_d      = prev_q;
    stable_d    = stable_q;
    value_d     = value_q;
    valid_d     = 1'b0;
    err_d       = 1'b0;
    err_digit_d = err_digit_q;

    if (dig != dig_q) begin
      dwell_d = 4'd0;
    end else if (dig_onehot && (dwell_q < SETTLE_L)) begin
      dwell_d = dwell_q + 4'd1;
    end

    if (frame_done) begin
      seen_d = 4'd0;
    end

    if (fire && !dec_ok) begin
      err_d       = 1'b1;
      err_digit_d = dig_idx;
      seen_d      = 4'd0;
      stable_d    = 3'd0;
    end else begin
      // A sample coinciding with the compare edge belongs to the next frame.
      if (fire) begin
        slot_d[dig_idx*4 +: 4] = dec_nib;
        seen_d[dig_idx]        = 1'b1;
      end
      if (frame_done) begin
        if ((stable_q != 3'd0) && (slot_q == prev_q)) begin
          if (stable_q < STABLE_L) begin
            stable_d = stable_q + 3'd1;
            if (stable_q == STABLE_M1) begin
              value_d = slot_q;
              valid_d = 1'b1;
            end
          end
        end else begin
          prev_d   = slot_q;
          stable_d = 3'd1;
          if (STABLE_L == 3'd1) begin
            value_d = slot_q;
            valid_d = 1'b1;
          end
        end
      end
    end
  end

`ifdef SEG_ERR_CNT_EN
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_d && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dig_q       <= 4'd0;
      dwell_q     <= 4'd0;
      slot_q      <= 16'd0;
      seen_q      <= 4'd0;
      prev_q      <= 16'd0;
      stable_q    <= 3'd0;
      value_q     <= 16'd0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
      err_digit_q <= 2'd0;
    end else begin
      dig_q       <= dig_d;
      dwell_q     <= dwell_d;
      slot_q      <= slot_d;
      seen_q      <= seen_d;
      prev_q      <= prev_d;
      stable_q    <= stable_d;
      value_q     <= value_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
      err_digit_q <= err_digit_d;
    end
  end

`ifdef SEG_ERR_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_cnt_q <= 8'd0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end
  assign err_cnt = err_cnt_q;
`endif

  assign value     = value_q;
  assign valid     = valid_q;
  assign err       = err_q;
  assign err_digit = err_digit_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb/tb_seg_scan_decoder.sv - directed self-checking bench for seg_scan_decoder
module tb_seg_scan_decoder;

  logic        clk;
  logic        rst_n;
  logic [6:0]  seg;
  logic [3:0]  dig;
  logic [15:0] value;
  logic        valid;
  logic        err;
  logic [1:0]  err_digit;
`ifdef SEG_ERR_CNT_EN
  logic [7:0]  err_cnt;
`endif

  int checks;
  int errors;
  int vcount;
  int ecount;
  int both_count;

  seg_scan_decoder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .seg       (seg),
    .dig       (dig),
    .value     (value),
    .valid     (valid),
    .err       (err),
`ifdef SEG_ERR_CNT_EN
    .err_digit (err_digit),
    .err_cnt   (err_cnt)
`else
    .err_digit (err_digit)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n) begin
      if (valid) vcount++;
      if (err) ecount++;
      if (valid && err) both_count++;
    end
  end

  function automatic logic [6:0] enc(input logic [3:0] h);
    case (h)
      4'h0: enc = 7'b0111111;
      4'h1: enc = 7'b0000110;
      4'h2: enc = 7'b1011011;
      4'h3: enc = 7'b1001111;
      4'h4: enc = 7'b1100110;
      4'h5: enc = 7'b1101101;
      4'h6: enc = 7'b1111101;
      4'h7: enc = 7'b0000111;
      4'h8: enc = 7'b1111111;
      4'h9: enc = 7'b1101111;
      4'hA: enc = 7'b1110111;
      4'hB: enc = 7'b1111100;
      4'hC: enc = 7'b0111001;
      4'hD: enc = 7'b1011110;
      4'hE: enc = 7'b1111001;
      default: enc = 7'b1110001;
    endcase
  endfunction

  task automatic cycles(input int n, input logic [3:0] d);
    dig = d;
    repeat (n) @(negedge clk);
  endtask

  // One scan: each digit shown 4 cycles; bad_digit (0..3) may get a forced pattern.
  task automatic scan(input logic [15:0] f, input int bad_digit, input logic [6:0] bad_pat);
    for (int k = 0; k < 4; k++) begin
      seg = (k == bad_digit) ? bad_pat : enc(f[k*4 +: 4]);
      cycles(4, 4'(1 << k));
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    dig   = 4'd0;
    seg   = 7'd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks += 4;
    if (value !== 16'h0) begin errors++; $display("FAIL reset_value got %h want 0000", value); end
    if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", valid); end
    if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err); end
    if (err_digit !== 2'd0) begin errors++; $display("FAIL reset_err_digit got %0d want 0", err_digit); end
  endtask

  task automatic test_basic();
    int v0;
    v0 = vcount;
    scan(16'h4321, -1, 7'd0);
    checks++;
    if (valid !== 1'b0) begin errors++; $display("FAIL basic_first_scan_valid got %b want 0", valid); end
    scan(16'h4321, -1, 7'd0);
    checks++;
    if (valid !== 1'b1) begin errors++; $display("FAIL basic_latency_valid got %b want 1", valid); end
    cycles(3, 4'd0);
    checks += 3;
    if (value !== 16'h4321) begin errors++; $display("FAIL basic_value got %h want 4321", value); end
    if (vcount - v0 != 1) begin errors++; $display("FAIL basic_pulses got %0d want 1", vcount - v0); end
    if (ecount != 0) begin errors++; $display("FAIL basic_err got %0d want 0", ecount); end
  endtask

  task automatic test_repeat();
    int v0;
    v0 = vcount;
    repeat (5) scan(16'h4321, -1, 7'd0);
    cycles(3, 4'd0);
    checks += 2;
    if (vcount - v0 != 0) begin errors++; $display("FAIL repeat_pulses got %0d want 0", vcount - v0); end
    if (value !== 16'h4321) begin errors++; $display("FAIL repeat_value got %h want 4321", value); end
  endtask

  task automatic test_err();
    int v0, e0;
    v0 = vcount;
    e0 = ecount;
    scan(16'hA5F0, 2, 7'b1010101);
    checks += 3;
    if (ecount - e0 != 1) begin errors++; $display("FAIL err_pulses got %0d want 1", ecount - e0); end
    if (err_digit !== 2'd2) begin errors++; $display("FAIL err_digit got %0d want 2", err_digit); end
    if (vcount - v0 != 0) begin errors++; $display("FAIL err_scan_valid got %0d want 0", vcount - v0); end
    scan(16'hA5F0, -1, 7'd0);
    scan(16'hA5F0, -1, 7'd0);
    cycles(3, 4'd0);
    checks += 2;
    if (value !== 16'hA5F0) begin errors++; $display("FAIL err_recover_value got %h want a5f0", value); end
    if (vcount - v0 != 1) begin errors++; $display("FAIL err_recover_pulses got %0d want 1", vcount - v0); end
  endtask

  task automatic test_alternate();
    int v0;
    v0 = vcount;
    for (int i = 0; i < 6; i++) scan((i % 2 == 0) ? 16'h1234 : 16'h1235, -1, 7'd0);
    cycles(3, 4'd0);
    checks += 2;
    if (vcount - v0 != 0) begin errors++; $display("FAIL alt_pulses got %0d want 0", vcount - v0); end
    if (value !== 16'hA5F0) begin errors++; $display("FAIL alt_value got %h want a5f0", value); end
  endtask

  task automatic test_reset_mid();
    int v0;
    for (int k = 0; k < 3; k++) begin
      seg = enc(4'h7);
      cycles(4, 4'(1 << k));
    end
    do_reset();
    checks += 4;
    if (value !== 16'h0) begin errors++; $display("FAIL mid_reset_value got %h want 0000", value); end
    if (valid !== 1'b0) begin errors++; $display("FAIL mid_reset_valid got %b want 0", valid); end
    if (err !== 1'b0) begin errors++; $display("FAIL mid_reset_err got %b want 0", err); end
    if (err_digit !== 2'd0) begin errors++; $display("FAIL mid_reset_err_digit got %0d want 0", err_digit); end
    v0 = vcount;
    scan(16'h00FF, -1, 7'd0);
    cycles(4, 4'd0);
    checks += 2;
    if (vcount - v0 != 0) begin errors++; $display("FAIL mid_single_scan_pulses got %0d want 0", vcount - v0); end
    if (value !== 16'h0) begin errors++; $display("FAIL mid_single_scan_value got %h want 0000", value); end
  endtask

  task automatic test_glitch();
    int v0, e0;
    do_reset();
    v0 = vcount;
    e0 = ecount;
    seg = enc(4'h9);
    cycles(4, 4'b0001);
    cycles(4, 4'b0010);
    seg = 7'b1010101;
    cycles(1, 4'b0100);
    cycles(10, 4'b0011);
    cycles(2, 4'b0000);
    checks += 3;
    if (dut.seen_q !== 4'b0011) begin errors++; $display("FAIL glitch_seen got %b want 0011", dut.seen_q); end
    if (vcount - v0 != 0) begin errors++; $display("FAIL glitch_valid got %0d want 0", vcount - v0); end
    if (ecount - e0 != 0) begin errors++; $display("FAIL glitch_err got %0d want 0", ecount - e0); end
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    vcount     = 0;
    ecount     = 0;
    both_count = 0;
    rst_n      = 1'b0;
    dig        = 4'd0;
    seg        = 7'd0;
    test_reset();
    test_basic();
    test_repeat();
    test_err();
    test_alternate();
    test_reset_mid();
    test_glitch();
    checks++;
    if (both_count != 0) begin errors++; $display("FAIL valid_err_overlap got %0d want 0", both_count); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
